// File: rtl/ppm_frame_sequencer.sv
// PPM receive frame sequencer: packs 2-bit symbols MSB-first into bytes between SOF and EOF, aborts with a coded cause.
// Latency: byte_valid_out rises 1 cycle after the 4th symbol strobe; status pulses 1 cycle after the closing event.
// Backpressure: single holding register with valid/ready; a byte completing while it is full and not draining aborts the frame.
module ppm_frame_sequencer #(
  parameter int MAX_LEN = 2048,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic             clk16,
  input  logic             rst_n,
  input  logic             sof_rcv_in,
  input  logic             eof_rcv_in,
  input  logic             sym_valid_in,
  input  logic [1:0]       sym_in,
  input  logic             sym_err_in,
  input  logic             byte_ready_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid_out,
  output logic             frame_active_out,
  output logic             frame_done_out,
  output logic             frame_err_out,
  output logic [2:0]       err_code_out,
  output logic [LEN_W-1:0] byte_count_out
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(TIMEOUT);

  localparam logic [2:0] E_TIMEOUT = 3'd1;
  localparam logic [2:0] E_PARTIAL = 3'd2;
  localparam logic [2:0] E_OVERRUN = 3'd3;
  localparam logic [2:0] E_SYMERR  = 3'd4;
  localparam logic [2:0] E_LENOVF  = 3'd5;
  localparam logic [2:0] E_RESTART = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_ASM, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  // Only the upper six bits need storage: the 4th symbol completes the byte directly.
  logic [5:0]       shift_q, shift_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       hold_dat_q, hold_dat_d;
  logic             hold_vld_q, hold_vld_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             drain;
  logic             complete;
  logic             load;
  logic [7:0]       new_byte;

  assign drain    = hold_vld_q & byte_ready_in;
  assign complete = sym_valid_in & (idx_q == 2'd3);
  assign new_byte = {shift_q, sym_in};

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      to_q       <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      hold_dat_q <= '0;
      hold_vld_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      hold_dat_q <= hold_dat_d;
      hold_vld_q <= hold_vld_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and frame bookkeeping, following the abort priority order inside a frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sof_rcv_in) begin
          state_d = S_ASM;
          idx_d   = '0;
          shift_d = '0;
          to_d    = '0;
          cnt_d   = '0;
          code_d  = '0;
        end
      end
      S_ASM: begin
        if (sym_valid_in && sym_err_in) begin
          state_d = S_ERR;
          code_d  = E_SYMERR;
        end else if (sof_rcv_in) begin
          state_d = S_ERR;
          code_d  = E_RESTART;
        end else if (complete && hold_vld_q && !drain) begin
          state_d = S_ERR;
          code_d  = E_OVERRUN;
        end else if (complete && (cnt_q == MAX_LEN_C)) begin
          state_d = S_ERR;
          code_d  = E_LENOVF;
        end else begin
          if (sym_valid_in) begin
            to_d  = '0;
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    shift_d[5:4] = sym_in;
              2'd1:    shift_d[3:2] = sym_in;
              2'd2:    shift_d[1:0] = sym_in;
              default: begin
                load  = 1'b1;
                cnt_d = (cnt_q == MAX_LEN_C) ? cnt_q : cnt_q + LEN_W'(1);
              end
            endcase
          end else begin
            to_d = to_q + TO_W'(1);
          end
          // EOF sees the index after this cycle's symbol has been absorbed.
          if (eof_rcv_in) begin
            if (idx_d == 2'd0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ERR;
              code_d  = E_PARTIAL;
            end
          end else if (to_d == TIMEOUT_C) begin
            state_d = S_ERR;
            code_d  = E_TIMEOUT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a new byte wins over a same-cycle drain so back-to-back bytes flow.
  always_comb begin
    hold_dat_d = hold_dat_q;
    hold_vld_d = hold_vld_q;
    if (load) begin
      hold_dat_d = new_byte;
      hold_vld_d = 1'b1;
    end else if (drain) begin
      hold_dat_d = '0;
      hold_vld_d = 1'b0;
    end
  end

  // Status outputs decoded from the next state so they line up with the state register.
  always_comb begin
    active_d = (state_d == S_ASM);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
  end

  assign byte_out         = hold_dat_q;
  assign byte_valid_out   = hold_vld_q;
  assign frame_active_out = active_q;
  assign frame_done_out   = done_q;
  assign frame_err_out    = err_q;
  assign err_code_out     = code_q;
  assign byte_count_out   = cnt_q;

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Bench for ppm_frame_sequencer: directed frames from the test plan followed by random traffic.
// Every cycle the DUT outputs are compared against a symbol-queue reference model.
// A small MAX_LEN is used so the length-overflow abort is reachable quickly.
module tb_ppm_frame_sequencer;

  localparam int MAXL = 4;
  localparam int LW   = 12;
  localparam int TMO  = 255;

  logic          clk16 = 1'b0;
  logic          rst_n;
  logic          sof_rcv_in, eof_rcv_in, sym_valid_in, sym_err_in, byte_ready_in;
  logic [1:0]    sym_in;
  logic [7:0]    byte_out;
  logic          byte_valid_out, frame_active_out, frame_done_out, frame_err_out;
  logic [2:0]    err_code_out;
  logic [LW-1:0] byte_count_out;

  always #5 clk16 = ~clk16;

  ppm_frame_sequencer #(.MAX_LEN(MAXL), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk16            (clk16),
    .rst_n            (rst_n),
    .sof_rcv_in       (sof_rcv_in),
    .eof_rcv_in       (eof_rcv_in),
    .sym_valid_in     (sym_valid_in),
    .sym_in           (sym_in),
    .sym_err_in       (sym_err_in),
    .byte_ready_in    (byte_ready_in),
    .byte_out         (byte_out),
    .byte_valid_out   (byte_valid_out),
    .frame_active_out (frame_active_out),
    .frame_done_out   (frame_done_out),
    .frame_err_out    (frame_err_out),
    .err_code_out     (err_code_out),
    .byte_count_out   (byte_count_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 in frame, 2 done pulse, 3 error pulse.
  int   ph, mcnt, mcode, mrun, mdat;
  bit   mvld;
  int   syms[$];
  int   got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; mcnt = 0; mcode = 0; mrun = 0; mdat = 0; mvld = 0;
    syms.delete();
  endtask

  task automatic abort(input int c);
    ph = 3;
    mcode = c;
    syms.delete();
  endtask

  task automatic check_all();
    chk("byte_valid", byte_valid_out, mvld);
    chk("byte_out", byte_out, mdat);
    chk("active", frame_active_out, ph == 1);
    chk("done", frame_done_out, ph == 2);
    chk("err", frame_err_out, ph == 3);
    chk("code", err_code_out, mcode);
    chk("count", byte_count_out, mcnt);
  endtask

  // One clock: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic cyc(input bit sof, input bit eof, input bit sv, input int sym, input bit serr, input bit rdy);
    bit drain, load, completes;
    int nb;
    sof_rcv_in = sof; eof_rcv_in = eof; sym_valid_in = sv; sym_in = 2'(sym);
    sym_err_in = serr; byte_ready_in = rdy;
    if (byte_valid_out && rdy) got.push_back(int'(byte_out));
    drain = mvld && rdy;
    load  = 0;
    nb    = 0;
    case (ph)
      0: if (sof) begin
        ph = 1; mcnt = 0; mcode = 0; mrun = 0; syms.delete();
      end
      1: begin
        completes = sv && (syms.size() == 3);
        if (sv && serr) abort(4);
        else if (sof) abort(6);
        else if (completes && mvld && !drain) abort(3);
        else if (completes && mcnt == MAXL) abort(5);
        else begin
          if (sv) begin
            mrun = 0;
            syms.push_back(sym);
            if (syms.size() == 4) begin
              nb = syms[0] * 64 + syms[1] * 16 + syms[2] * 4 + syms[3];
              load = 1;
              mcnt++;
              syms.delete();
            end
          end else begin
            mrun++;
          end
          if (eof) begin
            if (syms.size() == 0) ph = 2;
            else abort(2);
          end else if (mrun == TMO) begin
            abort(1);
          end
        end
      end
      default: ph = 0;
    endcase
    if (load) begin
      mvld = 1; mdat = nb;
    end else if (drain) begin
      mvld = 0; mdat = 0;
    end
    @(negedge clk16);
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic sym(input int v, input bit rdy);
    cyc(0, 0, 1, v, 0, rdy);
  endtask

  task automatic sof(input bit rdy);
    cyc(1, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    sof_rcv_in = 0; eof_rcv_in = 0; sym_valid_in = 0; sym_in = 0; sym_err_in = 0; byte_ready_in = 0;
    model_reset();
    @(negedge clk16);
    @(negedge clk16);
    check_all();
    rst_n = 1'b1;
    idle(2, 1);

    // Clean frame: 3,0,1,2 -> C6 and 0,1,2,3 -> 1B.
    got.delete();
    sof(1);
    sym(3, 1); sym(0, 1); sym(1, 1); sym(2, 1);
    sym(0, 1); sym(1, 1); sym(2, 1); sym(3, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("clean_done", frame_done_out, 1);
    chk("clean_cnt", byte_count_out, 2);
    idle(2, 1);
    chk("clean_n", got.size(), 2);
    chk("clean_b0", got.size() > 0 ? got[0] : -1, 32'hC6);
    chk("clean_b1", got.size() > 1 ? got[1] : -1, 32'h1B);

    // Backpressure: first byte held, second completes into a full register.
    got.delete();
    sof(0);
    sym(3, 0); sym(0, 0); sym(1, 0); sym(2, 0);
    sym(0, 0); sym(1, 0); sym(2, 0); sym(3, 0);
    chk("ovr_err", frame_err_out, 1);
    idle(3, 0);
    chk("ovr_code", err_code_out, 3);
    chk("ovr_held", byte_valid_out, 1);
    chk("ovr_none", got.size(), 0);
    idle(3, 1);
    chk("ovr_n", got.size(), 1);
    chk("ovr_b0", got.size() > 0 ? got[0] : -1, 32'hC6);

    // Partial byte at EOF.
    sof(1);
    for (int i = 0; i < 6; i++) sym(i % 4, 1);
    cyc(0, 1, 0, 0, 0, 1);
    idle(2, 1);
    chk("part_code", err_code_out, 2);
    chk("part_cnt", byte_count_out, 1);

    // EOF together with the 4th symbol closes cleanly.
    got.delete();
    sof(1);
    sym(0, 1); sym(1, 1); sym(2, 1);
    cyc(0, 1, 1, 3, 0, 1);
    chk("eof4_done", frame_done_out, 1);
    idle(2, 1);
    chk("eof4_code", err_code_out, 0);
    chk("eof4_b", got.size() > 0 ? got[0] : -1, 32'h1B);

    // Timeout after TMO idle cycles.
    sof(1);
    idle(TMO + 4, 1);
    chk("to_code", err_code_out, 1);

    // Symbol error.
    sof(1);
    sym(1, 1);
    cyc(0, 0, 1, 2, 1, 1);
    idle(2, 1);
    chk("serr_code", err_code_out, 4);

    // Restart by a second SOF mid-frame.
    sof(1);
    sym(1, 1); sym(2, 1);
    sof(1);
    idle(2, 1);
    chk("rst_code", err_code_out, 6);

    // Length overflow on byte MAXL+1.
    sof(1);
    for (int i = 0; i < 4 * (MAXL + 1); i++) sym(i % 4, 1);
    idle(2, 1);
    chk("ovf_code", err_code_out, 5);
    chk("ovf_cnt", byte_count_out, MAXL);

    // Asynchronous reset in the middle of a byte.
    sof(1);
    sym(2, 1); sym(1, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("ar_active", frame_active_out, 0);
    @(negedge clk16);
    rst_n = 1'b1;
    check_all();
    idle(3, 1);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 55,
          $urandom_range(0, 3), $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 70);
    end
    idle(5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
